cpi_sequencer: RTL

CPI_SEQUENCER -- requirements
Module: cpi_sequencer

---
 rtl/radar_sync_pkg.sv | 16 +
 rtl/pri_counter.sv | 46 ++++
 rtl/cpi_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/radar_sync_pkg.sv
// Shared types and default timing constants for the radar sync sequencer.
package radar_sync_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    PULSE = 2'd2,
    GAP   = 2'd3
  } state_t;

  // Defaults at 12 MHz: 200 us PRI, 40 us pulse, 500 ns switch lead.
  localparam int unsigned PRI_DEF   = 2400;
  localparam int unsigned WIDTH_DEF = 480;
  localparam int unsigned LEAD_DEF  = 6;

endpackage

// File: rtl/pri_counter.sv
// PRI phase counter and pulse-in-CPI counter with phase strobes for the sequencer.
module pri_counter #(
  parameter int unsigned CNT_W  = 12,
  parameter int unsigned CPI_W  = 8,
  parameter int unsigned LEAD_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              run,
  input  logic [CNT_W-1:0]  pri,
  input  logic [CNT_W-1:0]  width,
  input  logic [LEAD_W-1:0] lead,
  input  logic [CPI_W-1:0]  npulse,
  output logic              end_width_c,
  output logic              lead_pre_c,
  output logic              end_pri_c,
  output logic              last_pulse_c
);

  logic [CNT_W-1:0] pcnt;
  logic [CPI_W-1:0] pnum;
  logic [CNT_W-1:0] lead_at;

  // lead_pre_c marks the cycle just before the lead window so registered outputs land on its first cycle.
  assign lead_at      = pri - CNT_W'(lead) - CNT_W'(1);
  assign end_width_c  = (pcnt == width - CNT_W'(1));
  assign lead_pre_c   = (lead != '0) && (pcnt == lead_at);
  assign end_pri_c    = (pcnt == pri - CNT_W'(1));
  assign last_pulse_c = (pnum == npulse - CPI_W'(1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pcnt <= '0;
      pnum <= '0;
    end else if (run) begin
      if (end_pri_c) begin
        pcnt <= '0;
        pnum <= last_pulse_c ? '0 : pnum + CPI_W'(1);
      end else begin
        pcnt <= pcnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cpi_sequencer.sv
// CPI sequencer: PMT sync pulse train and alternating switch control per coherent processing interval.
module cpi_sequencer
  import radar_sync_pkg::*;
#(
  parameter int unsigned CNT_W  = 12,
  parameter int unsigned CPI_W  = 8,
  parameter int unsigned LEAD_W = 4
) (
  input  logic              sysclk,
  input  logic              btn,
  input  logic              start,
  input  logic              stop,
  input  logic [CNT_W-1:0]  cfg_pri,
  input  logic [CNT_W-1:0]  cfg_width,
  input  logic [LEAD_W-1:0] cfg_lead,
  input  logic [CPI_W-1:0]  cfg_npulse,
  input  logic [CPI_W-1:0]  cfg_ncpi,
  output logic              pmt_sync,
  output logic              sw_ctrl,
  output logic              busy,
  output logic [CPI_W-1:0]  cpi_idx,
  output logic              cpi_done,
  output logic              cfg_err
);

  state_t            state;
  logic [CNT_W-1:0]  pri_q;
  logic [CNT_W-1:0]  width_q;
  logic [LEAD_W-1:0] lead_q;
  logic [CPI_W-1:0]  npulse_q;
  logic [CPI_W-1:0]  ncpi_q;
  logic [LEAD_W-1:0] lead_cnt;
  logic              stop_flag;
  logic              cont_q;

  logic              run;
  logic              end_width;
  logic              lead_pre;
  logic              end_pri;
  logic              last_pulse;
  logic              cfg_bad;
  logic              ending;
  logic              continuing;
  logic [CPI_W-1:0]  idx_next;

  assign run = (state == PULSE) || (state == GAP);

  assign cfg_bad = (cfg_width == '0) || (cfg_width >= cfg_pri) || (cfg_npulse == '0) ||
                   (CNT_W'(cfg_lead) > cfg_pri - cfg_width);

  assign idx_next   = cpi_idx + CPI_W'(1);
  assign ending     = stop_flag || stop || ((ncpi_q != '0) && (idx_next == ncpi_q));
  // With no lead window the decision is taken on the final GAP edge itself.
  assign continuing = (lead_q == '0) ? !ending : cont_q;

  pri_counter #(
    .CNT_W  (CNT_W),
    .CPI_W  (CPI_W),
    .LEAD_W (LEAD_W)
  ) u_pri_counter (
    .clk          (sysclk),
    .rst          (btn),
    .clear        (!run),
    .run          (run),
    .pri          (pri_q),
    .width        (width_q),
    .lead         (lead_q),
    .npulse       (npulse_q),
    .end_width_c  (end_width),
    .lead_pre_c   (lead_pre),
    .end_pri_c    (end_pri),
    .last_pulse_c (last_pulse)
  );

  always_ff @(posedge sysclk) begin
    if (btn) begin
      state     <= IDLE;
      pri_q     <= '0;
      width_q   <= '0;
      lead_q    <= '0;
      npulse_q  <= '0;
      ncpi_q    <= '0;
      lead_cnt  <= '0;
      stop_flag <= 1'b0;
      cont_q    <= 1'b0;
      pmt_sync  <= 1'b0;
      sw_ctrl   <= 1'b0;
      busy      <= 1'b0;
      cpi_idx   <= '0;
      cpi_done  <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cpi_done <= 1'b0;
      if (stop && (state != IDLE)) stop_flag <= 1'b1;

      // Freeze continue/stop at the lead window of the CPI's last PRI and pre-swing the switch.
      if (run && lead_pre && last_pulse) begin
        cont_q <= !ending;
        if (!ending) sw_ctrl <= cpi_idx[0];
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_bad) begin
              cfg_err <= 1'b1;
            end else begin
              pri_q     <= cfg_pri;
              width_q   <= cfg_width;
              lead_q    <= cfg_lead;
              npulse_q  <= cfg_npulse;
              ncpi_q    <= cfg_ncpi;
              cfg_err   <= 1'b0;
              cpi_idx   <= '0;
              stop_flag <= stop;
              lead_cnt  <= '0;
              cont_q    <= 1'b0;
              sw_ctrl   <= 1'b1;
              busy      <= 1'b1;
              if (cfg_lead == '0) begin
                state    <= PULSE;
                pmt_sync <= 1'b1;
              end else begin
                state    <= ARM;
                pmt_sync <= 1'b0;
              end
            end
          end
        end
        ARM: begin
          if (lead_cnt == lead_q - LEAD_W'(1)) begin
            state    <= PULSE;
            pmt_sync <= 1'b1;
          end else begin
            lead_cnt <= lead_cnt + LEAD_W'(1);
          end
        end
        PULSE: begin
          if (end_width) begin
            state    <= GAP;
            pmt_sync <= 1'b0;
          end
        end
        GAP: begin
          if (end_pri) begin
            if (last_pulse) begin
              cpi_done <= 1'b1;
              cpi_idx  <= idx_next;
              if (continuing) begin
                state    <= PULSE;
                pmt_sync <= 1'b1;
                sw_ctrl  <= ~idx_next[0];
              end else begin
                state     <= IDLE;
                pmt_sync  <= 1'b0;
                sw_ctrl   <= 1'b0;
                busy      <= 1'b0;
                stop_flag <= 1'b0;
              end
            end else begin
              state    <= PULSE;
              pmt_sync <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
